// File: rtl/tmr_pkg.sv
// tmr_pkg: shared state encoding, event ids and helpers for the TMR fault monitor.
package tmr_pkg;
    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEGRADED = 2'd2,
        ST_FAILED   = 2'd3
    } tmr_state_e;

    localparam logic [1:0] EVT_TRIPLE = 2'd0;
    localparam logic [1:0] EVT_R1     = 2'd1;
    localparam logic [1:0] EVT_R2     = 2'd2;
    localparam logic [1:0] EVT_R3     = 2'd3;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction
endpackage

// File: rtl/tmr_disagree_classifier.sv
// tmr_disagree_classifier: combinational vote telling which single replica disagrees, or that all three differ.
module tmr_disagree_classifier #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] q_1,
    input  logic [WIDTH-1:0] q_2,
    input  logic [WIDTH-1:0] q_3,
    output logic [2:0]       single,
    output logic             triple
);
    logic eq12, eq13, eq23;

    always_comb begin
        eq12 = q_1 == q_2;
        eq13 = q_1 == q_3;
        eq23 = q_2 == q_3;
        // The odd one out is the replica excluded from the only agreeing pair.
        single[0] = eq23 & ~eq12;
        single[1] = eq13 & ~eq12;
        single[2] = eq12 & ~eq13;
        triple    = ~eq12 & ~eq13 & ~eq23;
    end
endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: counts replica disagreements, tracks replica health and
// reports each fault through a single-entry valid/ready event slot.
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int CNT_W       = 8,
    parameter int FAIL_THRESH = 4,
    parameter int QUIET       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] q_1,
    input  logic [WIDTH-1:0] q_2,
    input  logic [WIDTH-1:0] q_3,
    input  logic             clear,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [1:0]       evt_id,
    output logic             evt_overflow,
    output logic [1:0]       state,
    output logic [2:0]       fail_mask,
    output logic [CNT_W-1:0] fault_cnt_1,
    output logic [CNT_W-1:0] fault_cnt_2,
    output logic [CNT_W-1:0] fault_cnt_3
);
    localparam int QW = $clog2(QUIET + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] single, smp_single;
    logic       triple, smp_triple, smp_fault, consume;
    logic [1:0] n_fail;

    tmr_state_e             state_q, state_d;
    logic [2:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]             mask_q, mask_d;
    logic [QW-1:0]          quiet_q, quiet_d;
    logic                   evt_valid_q, evt_valid_d;
    logic [1:0]             evt_id_q, evt_id_d;
    logic                   ovf_q, ovf_d;

    tmr_disagree_classifier #(.WIDTH(WIDTH)) u_classifier (
        .q_1    (q_1),
        .q_2    (q_2),
        .q_3    (q_3),
        .single (single),
        .triple (triple)
    );

    always_comb begin
        smp_single = sample_en ? single : 3'b000;
        smp_triple = sample_en & triple;
        smp_fault  = (smp_single != 3'b000) | smp_triple;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]  = cnt_q[i] + CNT_W'(smp_single[i] && cnt_q[i] != CNT_MAX);
            mask_d[i] = mask_q[i] | (cnt_d[i] >= CNT_W'(FAIL_THRESH));
        end
        n_fail  = popcnt3(mask_d);
        state_d = state_q;
        quiet_d = '0;
        if (state_q == ST_FAILED || smp_triple || n_fail >= 2'd2)
            state_d = ST_FAILED;
        else if (state_q == ST_DEGRADED || n_fail == 2'd1)
            state_d = ST_DEGRADED;
        else if (smp_single != 3'b000)
            state_d = ST_SUSPECT;
        else if (state_q == ST_SUSPECT) begin
            quiet_d = sample_en ? quiet_q + 1'b1 : quiet_q;
            state_d = quiet_d == QW'(QUIET) ? ST_OK : ST_SUSPECT;
            quiet_d = quiet_d == QW'(QUIET) ? '0 : quiet_d;
        end
        // A consumed slot frees up on the same edge, so a new fault can take it.
        consume     = evt_valid_q & evt_ready;
        evt_valid_d = evt_valid_q & ~consume;
        evt_id_d    = evt_id_q;
        ovf_d       = ovf_q | (smp_fault & evt_valid_d);
        if (smp_fault && !evt_valid_d) begin
            evt_valid_d = 1'b1;
            evt_id_d    = triple ? EVT_TRIPLE : single[0] ? EVT_R1 : single[1] ? EVT_R2 : EVT_R3;
        end
        if (clear) begin
            state_d     = ST_OK;
            cnt_d       = '0;
            mask_d      = '0;
            quiet_d     = '0;
            evt_valid_d = 1'b0;
            evt_id_d    = EVT_TRIPLE;
            ovf_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_OK;
            cnt_q       <= '0;
            mask_q      <= '0;
            quiet_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= EVT_TRIPLE;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            quiet_q     <= quiet_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_id_q;
    assign evt_overflow = ovf_q;
    assign state        = state_q;
    assign fail_mask    = mask_q;
    assign fault_cnt_1  = cnt_q[0];
    assign fault_cnt_2  = cnt_q[1];
    assign fault_cnt_3  = cnt_q[2];
endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 128: replica word width.
REQ-002 SHALL have parameter CNT_W, default 8: per-replica fault-counter width.
REQ-003 SHALL have parameter FAIL_THRESH, default 4: fault count at which a replica is declared failed.
REQ-004 SHALL have parameter QUIET, default 16: number of fault-free sampled cycles needed to leave SUSPECT.
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Ports are clk and rst (rst active-low).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous reset, active-low.
REQ-008 sample_en  input  1  replicas are evaluated this cycle.
REQ-009 q_1, q_2, q_3  input  WIDTH each  replica counter values.
REQ-010 clear  input  1  synchronous clear of counters, mask, state and overflow.
REQ-011 evt_ready  input  1  consumer accepts the event.
REQ-012 evt_valid  output  1  event pending.
REQ-013 evt_id  output  2  1/2/3 = single faulty replica; 0 = triple disagreement.
REQ-014 evt_overflow  output  1  sticky: an event was dropped.
REQ-015 state  output  2  OK=0, SUSPECT=1, DEGRADED=2, FAILED=3.
REQ-016 fail_mask  output  3  bit i-1 set = replica i declared failed (sticky).
REQ-017 fault_cnt_1, fault_cnt_2, fault_cnt_3  output  CNT_W each  per-replica fault counts.

Function
REQ-018 SHALL classify each sampled cycle combinationally:
  - all equal -> no fault;
  - exactly one replica differs from the two agreeing ones -> single fault on that replica;
  - all pairwise different -> triple fault.
REQ-019 A single fault on replica i SHALL increment fault_cnt_i by 1 at the next clk edge; the counter saturates at 2^CNT_W-1. A triple fault SHALL increment no counter.
REQ-020 SHALL set fail_mask bit i on the edge where fault_cnt_i reaches FAIL_THRESH.
REQ-021 When sample_en=0, SHALL update no counter, event or state, and SHALL hold the quiet timer.
REQ-022 FSM transitions, each taking effect at the next edge:
  - OK -> SUSPECT on any single fault;
  - SUSPECT -> OK after QUIET consecutive sampled fault-free cycles; any fault restarts the quiet timer;
  - OK/SUSPECT -> DEGRADED when exactly one fail_mask bit is set;
  - any state -> FAILED on a triple fault or when two or more fail_mask bits are set;
  - DEGRADED stays until FAILED or clear; FAILED stays until clear.
REQ-023 Event slot: one entry. A sampled fault SHALL load {evt_valid=1, evt_id} at the next edge, giving 1-cycle latency.
REQ-024 Event handshake: evt_valid=1 and evt_ready=1 on an edge consumes the event. evt_valid and evt_id SHALL stay stable until consumed.
REQ-025 New fault arriving while an event is pending and not being consumed: the new event SHALL be dropped and evt_overflow set. If the pending event is consumed on the same edge, the new event SHALL load and no overflow occurs.
REQ-026 clear SHALL zero counters, fail_mask, evt_overflow, evt_valid and the quiet timer, and set state to OK. clear SHALL win over a fault on the same cycle.

Reset
REQ-027 rst low SHALL asynchronously force:
  - state=OK;
  - fail_mask=0;
  - all fault_cnt=0;
  - evt_valid=0, evt_id=0, evt_overflow=0;
  - quiet timer=0.
REQ-028 Reset assertion mid-operation SHALL discard any pending event. The first sampled cycle after deassertion SHALL be evaluated normally.

Structure
REQ-029 Package tmr_pkg SHALL hold the state enum and the evt_id encodings (EVT_TRIPLE=0, EVT_R1..R3=1..3).
REQ-030 Classification SHALL live in sub-module tmr_disagree_classifier (combinational), with outputs single[2:0] and triple. All registers SHALL be in tmr_fault_monitor.

Verification
REQ-031 Reset then q_1=q_2=q_3=5 for 20 sampled cycles -> state=OK, counts 0, evt_valid=0.
REQ-032 One cycle with q_2=7, q_1=q_3=5, evt_ready=1 -> next cycle evt_valid=1, evt_id=2, fault_cnt_2=1, state=SUSPECT. After 16 clean sampled cycles -> state=OK.
REQ-033 Four q_3 faults, evt_ready=1 -> fault_cnt_3=4, fail_mask=3'b100, state=DEGRADED. A later triple fault (1,2,3) -> state=FAILED and evt_id=0.
REQ-034 evt_ready=0 with q_1 faults on two consecutive cycles -> evt_id=1 held, evt_overflow=1, fault_cnt_1=2.
REQ-035 Fault and clear on the same cycle -> all counts 0, state=OK, evt_valid=0. Separately, rst asserted while evt_valid=1 -> evt_valid=0 immediately, without waiting for a clock edge.
